// File: rtl/led_matrix_scanner.sv
// rtl/led_matrix_scanner.sv - double-buffered 8x8 LED matrix frame buffer and row scanner
module led_matrix_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] row1,
  input  logic [7:0] row2,
  input  logic [7:0] row3,
  input  logic [7:0] row4,
  input  logic [7:0] row5,
  input  logic [7:0] row6,
  input  logic [7:0] row7,
  input  logic [7:0] row8,
  input  logic       load,
  input  logic       swap,
  output logic       swap_pending,
  output logic [7:0] row_sel,
  output logic [7:0] col_data,
  output logic [2:0] scan_row,
  output logic       frame_done
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  // Index 0 is matrix row 0 (row1); bit 7 of each byte is column 0.
  logic [7:0][7:0] rows;
  logic [7:0][7:0] back;
  logic [7:0][7:0] disp;
  logic [DW-1:0]   div;
  logic [2:0]      row;
  logic            pend;
  logic            frame_q;
  logic            row_end;
  logic            wrap;
  logic            blank;

  assign rows    = {row8, row7, row6, row5, row4, row3, row2, row1};
  assign row_end = (div == DIV_LAST);
  assign wrap    = row_end && (row == 3'd7);

  // Blanking window at the head of every row period; absent entirely when BLANK_CYCLES is 0.
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign blank = 1'b0;
  end else begin : g_blank
    localparam logic [DW-1:0] BLANK_END = DW'(BLANK_CYCLES);
    assign blank = (div < BLANK_END);
  end

  // Scan counters, frame pulse, and back/display buffer management.
  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= '0;
      row     <= '0;
      pend    <= 1'b0;
      frame_q <= 1'b0;
      back    <= '0;
      disp    <= '0;
    end else begin
      frame_q <= wrap;
      if (row_end) begin
        div <= '0;
        row <= row + 3'd1;
      end else begin
        div <= div + DW'(1);
      end

      // A transfer replaces back; a load in the same cycle seeds the fresh back buffer.
      if (wrap && pend) begin
        disp <= back;
        back <= load ? rows : '0;
        pend <= 1'b0;
      end else begin
        if (load) begin
          back <= back | rows;
        end
        if (swap) begin
          pend <= 1'b1;
        end
      end
    end
  end

  // Panel drive decoded from registered state only.
  always_comb begin
    row_sel  = 8'h00;
    col_data = 8'hFF;
    if (!blank) begin
      row_sel  = 8'h01 << row;
      col_data = ~disp[row];
    end
  end

  assign scan_row     = row;
  assign frame_done   = frame_q;
  assign swap_pending = pend;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb/tb_led_matrix_scanner.sv - randomized and directed self-checking bench for led_matrix_scanner
module tb_led_matrix_scanner;

  localparam int SD = 4;
  localparam int BC = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            load = 1'b0;
  logic            swap = 1'b0;
  logic [7:0][7:0] drv = '0;
  logic            swap_pending;
  logic [7:0]      row_sel;
  logic [7:0]      col_data;
  logic [2:0]      scan_row;
  logic            frame_done;

  int total = 0;
  int bad   = 0;

  // Reference state: time since reset release plus the two buffers and the pending flag.
  int              t = 0;
  logic [7:0][7:0] m_back = '0;
  logic [7:0][7:0] m_disp = '0;
  bit              m_pend = 0;
  bit              m_fd = 0;

  led_matrix_scanner #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst),
    .row1(drv[0]), .row2(drv[1]), .row3(drv[2]), .row4(drv[3]),
    .row5(drv[4]), .row6(drv[5]), .row7(drv[6]), .row8(drv[7]),
    .load(load), .swap(swap),
    .swap_pending(swap_pending), .row_sel(row_sel), .col_data(col_data),
    .scan_row(scan_row), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  function automatic int m_row();
    return (t / SD) % 8;
  endfunction

  function automatic int m_div();
    return t % SD;
  endfunction

  task automatic check_outputs();
    bit lit;
    lit = (m_div() >= BC);
    check("row_sel", row_sel, lit ? (32'd1 << m_row()) : 32'h00);
    check("col_data", col_data, lit ? {24'h0, ~m_disp[m_row()]} : 32'hFF);
    check("scan_row", scan_row, m_row());
    check("frame_done", frame_done, m_fd);
    check("swap_pending", swap_pending, m_pend);
  endtask

  // One clock: drive strobes, advance the reference at the edge, compare at the falling edge.
  task automatic tick(input bit ld, input bit sw, input bit rs);
    bit wrap;
    load = ld;
    swap = sw;
    rst  = rs;
    @(posedge clk);
    if (rs) begin
      m_back = '0;
      m_disp = '0;
      m_pend = 0;
      m_fd   = 0;
      t      = 0;
    end else begin
      wrap = (m_div() == SD - 1) && (m_row() == 7);
      m_fd = wrap;
      if (wrap && m_pend) begin
        m_disp = m_back;
        m_back = ld ? drv : '0;
        m_pend = 0;
      end else begin
        if (ld) m_back = m_back | drv;
        if (sw) m_pend = 1;
      end
      t++;
    end
    @(negedge clk);
    load = 1'b0;
    swap = 1'b0;
    rst  = 1'b0;
    check_outputs();
  endtask

  // Idle until the scan sits at (row r, div d); bounded by one frame.
  task automatic go(input int r, input int d);
    for (int n = 0; n <= 8 * SD + 1; n++) begin
      if (m_row() == r && m_div() == d) return;
      tick(0, 0, 0);
    end
    check("go_timeout", 0, 1);
  endtask

  task automatic load_row(input int idx, input logic [7:0] v);
    drv = '0;
    drv[idx] = v;
    tick(1, 0, 0);
    drv = '0;
  endtask

  logic [7:0] pat [8] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h02, 8'h02, 8'h02};

  initial begin
    @(negedge clk);
    // 1: reset, idle, scan pattern and frame pulses
    tick(0, 0, 1);
    for (int k = 0; k <= 64; k++) begin
      if (k < 8) check("t1_row_sel", row_sel, pat[k]);
      if (k == 32 || k == 64) check("t1_frame_done", frame_done, 1);
      check("t1_col_idle", col_data, 8'hFF);
      if (k < 64) tick(0, 0, 0);
    end

    // 2: two single points, then swap
    load_row(0, 8'h80);
    load_row(2, 8'h01);
    tick(0, 1, 0);
    go(7, SD - 1);
    tick(0, 0, 0);
    go(0, 1); check("t2_row0", col_data, 8'h7F);
    go(1, 1); check("t2_row1", col_data, 8'hFF);
    go(2, 1); check("t2_row2", col_data, 8'hFE);

    // 3: swap mid-frame at row 3
    load_row(7, 8'h3C);
    go(3, 2);
    tick(0, 1, 0);
    check("t3_pend_set", swap_pending, 1);
    go(7, SD - 1);
    check("t3_pend_hold", swap_pending, 1);
    check("t3_old_row7", col_data, 8'hFF);
    tick(0, 0, 0);
    check("t3_pend_drop", swap_pending, 0);
    go(7, 1); check("t3_new_row7", col_data, 8'hC3);

    // 4: swap+load on the wrap with nothing pending; second swap ignored
    go(7, SD - 1);
    drv = '0; drv[1] = 8'h22;
    tick(1, 1, 0);
    drv = '0;
    check("t4_pend_set", swap_pending, 1);
    go(1, 1); check("t4_not_yet", col_data, 8'hFF);
    tick(0, 1, 0);
    check("t4_pend_still", swap_pending, 1);
    go(7, SD - 1);
    tick(0, 0, 0);
    check("t4_pend_clear", swap_pending, 0);
    go(1, 1); check("t4_row1", col_data, 8'hDD);
    go(7, SD - 1);
    tick(0, 0, 0);
    go(1, 1); check("t4_single_xfer", col_data, 8'hDD);

    // 5: load on the transfer cycle seeds the new back buffer
    load_row(0, 8'h01);
    tick(0, 1, 0);
    go(7, SD - 1);
    drv = '0; drv[4] = 8'h10;
    tick(1, 0, 0);
    drv = '0;
    go(0, 1); check("t5_old_back", col_data, 8'hFE);
    tick(0, 1, 0);
    go(7, SD - 1);
    tick(0, 0, 0);
    go(0, 1); check("t5_row0", col_data, 8'hFF);
    go(4, 1); check("t5_row4", col_data, 8'hEF);

    // 6: reset mid row 5 with a swap pending and a lit display
    load_row(5, 8'h20);
    tick(0, 1, 0);
    go(7, SD - 1);
    tick(0, 0, 0);
    go(5, 1); check("t6_lit", col_data, 8'hDF);
    load_row(3, 8'h55);
    tick(0, 1, 0);
    go(5, 2);
    tick(0, 0, 1);
    check("t6_row_sel", row_sel, 8'h00);
    check("t6_col", col_data, 8'hFF);
    check("t6_scan_row", scan_row, 0);
    check("t6_fd", frame_done, 0);
    check("t6_pend", swap_pending, 0);
    go(7, SD - 1);
    tick(0, 0, 0);
    go(3, 1); check("t6_no_xfer", col_data, 8'hFF);
    go(5, 1); check("t6_disp_clear", col_data, 8'hFF);

    // Random traffic against the reference
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 8; i++) drv[i] = 8'($urandom);
      tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
